// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial "101" scanner.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/seq_bit_matcher.sv
// Two-bit pattern history and hit term for the serial scanner.
// SEQ_SCAN_OVERLAP_EN: matches may share bits when defined.
module seq_bit_matcher
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    logic [1:0] hist;
    logic [1:0] hist_nxt;

    assign hit = (hist == PATTERN[2:1])
              && (bit_in == PATTERN[0]);

    always_comb begin
        hist_nxt = {hist[0], bit_in};
`ifndef SEQ_SCAN_OVERLAP_EN
        // a consumed match must not donate bits to the next one
        if (hit)
            hist_nxt = 2'b00;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            hist <= 2'b00;
        else if (clear)
            hist <= 2'b00;
        else if (en)
            hist <= hist_nxt;
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-serial "101" scanner: IDLE accept, SHIFT MSB-first, REPORT count.
// SEQ_SCAN_OVERLAP_EN selects overlapping matches.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  match_count,
    output logic              count_valid,
    output logic              busy
);

    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;

    logic [WORD_W-1:0] sreg;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  mc_q;

    logic accept;
    logic shifting;
    logic clear;
    logic cur_bit;
    logic hit;
    logic last_bit;

    assign word_ready = (state == IDLE);
    assign accept     = word_valid && word_ready;
    assign shifting   = (state == SHIFT);
    assign clear      = flush && (state == IDLE);
    assign cur_bit    = sreg[WORD_W-1];
    assign last_bit   = (bit_cnt == BC_W'(WORD_W - 1));

    assign count_valid = (state == REPORT);
    assign busy        = !word_ready;
    assign match_count = count_valid ? hit_cnt : mc_q;

    seq_bit_matcher u_match (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .en     (shifting),
        .bit_in (cur_bit),
        .hit    (hit)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
            hit_cnt <= '0;
            mc_q    <= '0;
        end else begin
            if (accept) begin
                sreg    <= word_in;
                bit_cnt <= '0;
                hit_cnt <= '0;
            end else if (shifting) begin
                sreg    <= {sreg[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                if (hit && (hit_cnt != CNT_MAX))
                    hit_cnt <= hit_cnt + 1'b1;
            end
            // keep the reported value visible after REPORT
            if (count_valid)
                mc_q <= hit_cnt;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (default and CNT_W=2 instances).
// Honours SEQ_SCAN_OVERLAP_EN when computing expected counts.
module tb_seq_scan_ctrl;

`ifdef SEQ_SCAN_OVERLAP_EN
    localparam int E_A8   = 2;
    localparam int E_AD   = 3;
    localparam int E_40F  = 0;
    localparam int E_AA1  = 3;
    localparam int E_AA2  = 4;
    localparam int E_AA2S = 3;
`else
    localparam int E_A8   = 1;
    localparam int E_AD   = 2;
    localparam int E_40F  = 0;
    localparam int E_AA1  = 2;
    localparam int E_AA2  = 2;
    localparam int E_AA2S = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] word_in;
    logic       word_valid;
    logic       flush;
    logic       word_ready;
    logic [3:0] match_count;
    logic       count_valid;
    logic       busy;
    logic       word_ready_s;
    logic [1:0] match_count_s;
    logic       count_valid_s;
    logic       busy_s;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .flush       (flush),
        .match_count (match_count),
        .count_valid (count_valid),
        .busy        (busy)
    );

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready_s),
        .flush       (flush),
        .match_count (match_count_s),
        .count_valid (count_valid_s),
        .busy        (busy_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic run_word(input  logic [7:0] w,
                            input  logic       fl_acc,
                            input  logic       fl_busy,
                            output int         cyc,
                            output logic [3:0] c,
                            output logic [1:0] cs);
        word_in    = w;
        word_valid = 1'b1;
        flush      = fl_acc;
        step();
        cyc        = 1;
        word_valid = 1'b0;
        flush      = fl_busy;
        while (!count_valid && cyc < 20) begin
            step();
            cyc++;
        end
        c  = match_count;
        cs = match_count_s;
        step();
        flush = 1'b0;
    endtask

    int         cyc;
    logic [3:0] c;
    logic [1:0] cs;
    int         acc[2];
    int         na;
    int         low;
    int         np;
    logic [3:0] vals[2];
    int         cv_seen;

    initial begin
        reset      = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        flush      = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_ready", word_ready, 1);
        check("rst_cv", count_valid, 0);
        check("rst_mc", match_count, 0);
        check("rst_mc_sat", match_count_s, 0);
        reset = 1'b0;
        step();

        run_word(8'hA8, 0, 0, cyc, c, cs);
        check("a8_latency", cyc, 9);
        check("a8_count", c, E_A8);
        check("a8_hold", match_count, E_A8);
        check("a8_cv_low", count_valid, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        run_word(8'hAD, 0, 0, cyc, c, cs);
        check("ad_count", c, E_AD);
        check("ad_count_sat", cs, E_AD);

        run_word(8'h40, 1, 0, cyc, c, cs);
        check("flush_accept", c, E_40F);

        flush = 1'b1;
        step();
        flush = 1'b0;
        run_word(8'h02, 0, 1, cyc, c, cs);
        check("carry_w1", c, 0);
        run_word(8'h80, 0, 0, cyc, c, cs);
        check("carry_w2", c, 1);

        run_word(8'h02, 0, 0, cyc, c, cs);
        check("flush_w1", c, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_word(8'h80, 0, 0, cyc, c, cs);
        check("flush_w2", c, 0);

        na  = 0;
        low = 0;
        np  = 0;
        word_in    = 8'hFF;
        word_valid = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (word_ready && word_valid && na < 2) begin
                acc[na] = t;
                na++;
            end
            if (!word_ready)
                low++;
            if (count_valid && np < 2) begin
                vals[np] = match_count;
                np++;
            end
            step();
            if (na == 1)
                word_in = 8'hA8;
            if (na == 2)
                word_valid = 1'b0;
        end
        check("b2b_accepts", na, 2);
        check("b2b_spacing", acc[1] - acc[0], 10);
        check("b2b_low", low, 18);
        check("b2b_pulses", np, 2);
        check("b2b_ff", vals[0], 0);
        check("b2b_a8", vals[1], E_A8);

        word_in    = 8'hAD;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", word_ready, 1);
        check("mid_rst_cv", count_valid, 0);
        reset   = 1'b0;
        cv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (count_valid)
                cv_seen++;
            step();
        end
        check("mid_rst_no_cv", cv_seen, 0);
        run_word(8'h05, 0, 0, cyc, c, cs);
        check("post_rst_05", c, 1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        run_word(8'hAA, 0, 0, cyc, c, cs);
        check("aa1_count", c, E_AA1);
        check("aa1_count_sat", cs, E_AA1);
        run_word(8'hAA, 0, 0, cyc, c, cs);
        check("aa2_count", c, E_AA2);
        check("aa2_count_sat", cs, E_AA2S);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter WORD_W, 8, width of each accepted data word in bits (>=3).
REQ-002 Parameter CNT_W, 4, width of match_count; the block SHALL saturate the count at 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 word_in  input  WORD_W  word to scan, shifted out MSB first.
REQ-006 word_valid  input  1  word_in is valid.
REQ-007 word_ready  output  1  block can accept a word this cycle.
REQ-008 flush  input  1  clears pattern history; honoured only in IDLE.
REQ-009 match_count  output  CNT_W  number of "101" hits found while scanning the last word.
REQ-010 count_valid  output  1  one-cycle pulse qualifying match_count.
REQ-011 busy  output  1  high in SHIFT and REPORT.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and REPORT.
REQ-013 IDLE: word_ready=1; on word_valid&&word_ready, load the shift register and clear bit_cnt and hit_cnt, then go to SHIFT.
REQ-014 SHIFT: each cycle, present the shift-register MSB as the current bit, shift left, increment bit_cnt; after the WORD_W-th bit go to REPORT.
REQ-015 The hit condition SHALL be the combinational term hist==2'b10 && bit==1, where hist[1] is the older bit.
REQ-016 Each SHIFT cycle, hist SHALL update to {hist[0], bit}; hit_cnt SHALL increment in the same cycle as a hit, saturating at 2^CNT_W-1.
REQ-017 REPORT: drive count_valid=1 and match_count=hit_cnt for exactly one cycle, then go to IDLE.
REQ-018 Latency: count_valid SHALL assert WORD_W+1 cycles after the accepting edge; the next accept SHALL be possible in the cycle after REPORT.
REQ-019 word_ready SHALL be 0 in SHIFT and REPORT; word_valid in those states SHALL be ignored, with no buffering.
REQ-020 hist SHALL carry across words; flush in IDLE SHALL set hist=00 on the next edge.
REQ-021 flush in SHIFT or REPORT SHALL be ignored.
REQ-022 If flush and an accept occur together in IDLE, both SHALL take effect, and the new word SHALL scan from hist=00.
REQ-023 match_count SHALL hold its last value outside REPORT.

Reset
REQ-024 On reset: state=IDLE, hist=00, bit_cnt=0, hit_cnt=0, match_count=0, count_valid=0, busy=0, word_ready=1 after the edge.
REQ-025 Reset SHALL take priority over all other inputs, including mid-SHIFT; the in-flight word SHALL be discarded with no count_valid pulse.

Configuration
REQ-026 Macro SEQ_SCAN_OVERLAP_EN defined: overlapping detection, with hist updating normally after a hit (1010 1 counts 2).
REQ-027 Macro SEQ_SCAN_OVERLAP_EN undefined: on a hit, hist SHALL be forced to 00 so matches never share bits.

Structure
REQ-028 Package seq_scan_pkg SHALL hold the FSM state typedef and the pattern constant PATTERN=3'b101.
REQ-029 One sub-module, seq_bit_matcher, SHALL hold hist, the hit term and the overlap macro, with ports clk, reset, clear, en, bit_in and hit.

Verification (WORD_W=8, CNT_W=4)
REQ-030 Reset, then word 0xA8 -> count_valid pulse 9 cycles after accept; match_count=2 with overlap, 1 without.
REQ-031 From reset, word 0xAD (1 0 1 0 1 1 0 1) -> match_count=3 with overlap, 2 without.
REQ-032 Carry: 0x02 then 0x80 with no flush -> counts 0 then 1; repeated with flush pulsed in IDLE between words -> 0 then 0.
REQ-033 word_valid held high with 0xFF, 0xA8 back-to-back -> word_ready low 9 cycles per word, exactly one count_valid per word, accepts 10 cycles apart.
REQ-034 Reset asserted in the 4th SHIFT cycle of 0xAD -> next cycle busy=0, word_ready=1, no count_valid; then 0x05 -> match_count=1.
REQ-035 Saturation with CNT_W=2 override: 0xAA then 0xAA without flush -> second count=3 (4 raw hits clipped) with overlap.
